// File: rtl/seqdet_pkg.sv
// -----------------------------------------------------------------------------
// seqdet_pkg
//   Shared types and reset constants for the serial pattern detector.
//   - seqdet_state_e : detector FSM state (IDLE / FILL / HUNT)
//   - RST_MASK_BIT   : reset value of every compare-mask bit (compare all bits)
//   - RST_OVERLAP    : reset value of the overlap-mode flag
// -----------------------------------------------------------------------------
package seqdet_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // detector disabled, window empty
    FILL = 2'd1,  // collecting bits, not enough history to match yet
    HUNT = 2'd2   // next accepted bit completes a full window
  } seqdet_state_e;

  localparam logic RST_MASK_BIT = 1'b1;
  localparam logic RST_OVERLAP  = 1'b1;

endpackage : seqdet_pkg

// File: rtl/seqdet_match_counter.sv
// -----------------------------------------------------------------------------
// seqdet_match_counter
//   Saturating event counter with synchronous clear. Clear wins over a
//   coincident increment.
//   Ports:
//     clk    in   1      clock, rising edge
//     rst    in   1      asynchronous, active-high reset
//     clr_i  in   1      synchronous clear
//     inc_i  in   1      count one event
//     cnt_o  out  CNT_W  events since clear, sticks at all-ones
// -----------------------------------------------------------------------------
module seqdet_match_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule : seqdet_match_counter

// File: rtl/seq_pattern_detector.sv
// -----------------------------------------------------------------------------
// seq_pattern_detector
//   Serial bit-pattern detector with a runtime-programmable PAT_W-bit pattern,
//   per-bit don't-care mask and overlapping / non-overlapping match mode.
//   Optional saturating match counter, built only when SEQDET_MATCH_CNT_EN is
//   defined; otherwise match_cnt is tied to zero and cnt_clr is ignored.
//   PAT_W must be >= 2.
//   Ports:
//     clk          in   1      clock, rising edge
//     rst          in   1      asynchronous, active-high reset
//     en           in   1      detector enable
//     din_valid    in   1      din qualifier
//     din          in   1      serial data bit
//     cfg_load     in   1      capture cfg_* and restart the window
//     cfg_pattern  in   PAT_W  pattern, bit 0 = most recent bit
//     cfg_mask     in   PAT_W  1 = compare bit, 0 = don't care
//     cfg_overlap  in   1      1 = overlapping, 0 = non-overlapping
//     cnt_clr      in   1      synchronous clear of match_cnt
//     match        out  1      combinational, high with the completing bit
//     fill         out  clog2(PAT_W+1)  valid bits in window, saturating
//     match_cnt    out  CNT_W  matches since clear
// -----------------------------------------------------------------------------
module seq_pattern_detector
  import seqdet_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         din_valid,
  input  logic                         din,
  input  logic                         cfg_load,
  input  logic [PAT_W-1:0]             cfg_pattern,
  input  logic [PAT_W-1:0]             cfg_mask,
  input  logic                         cfg_overlap,
  input  logic                         cnt_clr,
  output logic                         match,
  output logic [$clog2(PAT_W+1)-1:0]   fill,
  output logic [CNT_W-1:0]             match_cnt
);

  localparam int                FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_HUNT = FILL_W'(PAT_W - 1);

  // Only the PAT_W-1 most recent bits are stored: the newest bit of a
  // candidate window is always the one on din this cycle.
  logic [PAT_W-2:0]  win_q;
  logic [PAT_W-1:0]  win_d;
  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_d;
  logic [PAT_W-1:0]  pat_q;
  logic [PAT_W-1:0]  mask_q;
  logic              ovl_q;
  seqdet_state_e     state_q;
  logic              accept;
  logic              hit;

  // A load cycle discards din, so it never counts as an accepted bit.
  assign accept = en & din_valid & ~cfg_load;
  assign win_d  = {win_q, din};
  assign fill_d = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);

  // NOTE: match is deliberately combinational (Mealy) so the event is flagged
  // in the same cycle the completing bit is on din; register downstream if
  // timing requires.
  assign hit   = (state_q == HUNT) & accept & (((win_d ^ pat_q) & mask_q) == '0);
  assign match = hit;
  assign fill  = fill_q;

  // NOTE: every register here, configuration included, returns to its reset
  // value asynchronously; all sequential updates use non-blocking assignment
  // so the whole block reads pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      fill_q  <= '0;
      pat_q   <= '0;
      mask_q  <= {PAT_W{RST_MASK_BIT}};
      ovl_q   <= RST_OVERLAP;
    end else if (cfg_load) begin
      pat_q   <= cfg_pattern;
      mask_q  <= cfg_mask;
      ovl_q   <= cfg_overlap;
      win_q   <= '0;
      fill_q  <= '0;
      state_q <= en ? FILL : IDLE;
    end else if (!en) begin
      win_q   <= '0;
      fill_q  <= '0;
      state_q <= IDLE;
    end else if (hit && !ovl_q) begin
      // Non-overlapping: the completing bit is not reused in the next match.
      win_q   <= '0;
      fill_q  <= '0;
      state_q <= FILL;
    end else if (din_valid) begin
      win_q   <= win_d[PAT_W-2:0];
      fill_q  <= fill_d;
      state_q <= (fill_d >= FILL_HUNT) ? HUNT : FILL;
    end else if (state_q == IDLE) begin
      state_q <= FILL;
    end
  end

`ifdef SEQDET_MATCH_CNT_EN
  seqdet_match_counter #(
    .CNT_W (CNT_W)
  ) u_match_counter (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .inc_i (hit),
    .cnt_o (match_cnt)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule : seq_pattern_detector

// File: tb/tb_seq_pattern_detector.sv
// -----------------------------------------------------------------------------
// tb_seq_pattern_detector
//   Directed scoreboard bench for seq_pattern_detector (PAT_W=4, CNT_W=2).
//   The driver applies one cycle of stimulus per step and queues the expected
//   match/fill/match_cnt for that cycle; the monitor pops and compares on the
//   falling edge. Sequences are written as strings, one character per cycle:
//     '0'/'1' accepted bit, '.' din_valid=0, '_' en=0,
//     'c' en=0 with cnt_clr, 'C' accepted 1 with cnt_clr.
//   Expected strings: match per cycle, fill shown during the cycle, and
//   match_cnt shown during the cycle ('-' or empty string = not compared).
// -----------------------------------------------------------------------------
module tb_seq_pattern_detector;

  localparam int PAT_W  = 4;
  localparam int CNT_W  = 2;
  localparam int FILL_W = $clog2(PAT_W + 1);

`ifdef SEQDET_MATCH_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             din_valid = 1'b0;
  logic             din = 1'b0;
  logic             cfg_load = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [PAT_W-1:0] cfg_mask = '0;
  logic             cfg_overlap = 1'b0;
  logic             cnt_clr = 1'b0;
  logic             match;
  logic [FILL_W-1:0] fill;
  logic [CNT_W-1:0] match_cnt;

  typedef struct {
    string name;
    logic  match;
    int    fill;
    int    cnt;   // -1 = do not compare
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  seq_pattern_detector #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .din_valid   (din_valid),
    .din         (din),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_mask    (cfg_mask),
    .cfg_overlap (cfg_overlap),
    .cnt_clr     (cnt_clr),
    .match       (match),
    .fill        (fill),
    .match_cnt   (match_cnt)
  );

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: compare whatever the driver queued for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check({e.name, ".match"}, int'(match), int'(e.match));
        check({e.name, ".fill"}, int'(fill), e.fill);
        if (e.cnt >= 0)
          check({e.name, ".cnt"}, int'(match_cnt), CNT_ON ? e.cnt : 0);
      end
    end
  end

  // One cycle of stimulus; entered and left at posedge+1.
  task automatic step(input string tag, input logic e, input logic v, input logic d,
                      input logic ld, input logic clr, input logic exp_m,
                      input int exp_f, input int exp_c);
    exp_t item;
    en        = e;
    din_valid = v;
    din       = d;
    cfg_load  = ld;
    cnt_clr   = clr;
    item = '{name: tag, match: exp_m, fill: exp_f, cnt: exp_c};
    sb_q.push_back(item);
    @(posedge clk);
    #1;
  endtask

  task automatic seq(input string tag, input string bits, input string m_s,
                     input string f_s, input string c_s);
    byte  ch;
    logic e, v, d, clr;
    int   exp_c;
    for (int i = 0; i < bits.len(); i++) begin
      ch  = bits[i];
      e   = 1'b1;
      v   = 1'b1;
      d   = 1'b0;
      clr = 1'b0;
      case (ch)
        "1": d = 1'b1;
        ".": d = 1'b1 & ~(v = 1'b0);
        "_": begin e = 1'b0; d = 1'b1; end
        "c": begin e = 1'b0; clr = 1'b1; end
        "C": begin d = 1'b1; clr = 1'b1; end
        default: d = 1'b0;
      endcase
      exp_c = ((c_s.len() == 0) || (c_s[i] == "-")) ? -1 : int'(c_s[i] - "0");
      step($sformatf("%s[%0d]", tag, i), e, v, d, 1'b0, clr,
           m_s[i] == "1", int'(f_s[i] - "0"), exp_c);
    end
  endtask

  // Config load cycle: din=1 is offered and must be discarded, match forced 0.
  // The cfg_* inputs are scrambled afterwards so only the load edge captures.
  task automatic load(input string tag, input logic [PAT_W-1:0] p,
                      input logic [PAT_W-1:0] m, input logic o, input int exp_f);
    cfg_pattern = p;
    cfg_mask    = m;
    cfg_overlap = o;
    step(tag, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, exp_f, -1);
    cfg_pattern = ~p;
    cfg_mask    = ~m;
    cfg_overlap = ~o;
  endtask

  initial begin
    // Power-on reset values.
    #3;
    check("por.match", int'(match), 0);
    check("por.fill", int'(fill), 0);
    check("por.cnt", int'(match_cnt), 0);
    #9 rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset config: pattern 0000, mask 1111, overlap on; fill saturates at 4.
    seq("rstcfg", "000001_", "0001100", "0123444", "");

    // Run-of-three detect via mask 0111 (equivalent to a 3-bit window).
    load("ld_run", 4'b0111, 4'b0111, 1'b1, 0);
    seq("run3", "0111110", "0001110", "0123444", "");

    // 1011 non-overlapping then overlapping.
    load("ld_novl", 4'b1011, 4'b1111, 1'b0, 4);
    seq("novl", "1011011", "0001000", "0123012", "");
    load("ld_ovl", 4'b1011, 4'b1111, 1'b1, 3);
    seq("ovl", "1011011", "0001001", "0123444", "");

    // Don't-care bits, then the same match stretched by din_valid gaps.
    load("ld_dc", 4'b1001, 4'b1001, 1'b1, 4);
    seq("dc_gap", "1111_1.1..1.1", "0001000000001", "0123401122233", "");

    // Load one bit before completion: completing bit discarded, restart.
    load("ld_pre", 4'b1011, 4'b1111, 1'b1, 4);
    seq("pre_ld", "101", "000", "012", "");
    load("ld_mid", 4'b1011, 4'b1111, 1'b1, 3);
    seq("post_ld", "1011", "0001", "0123", "");

    // en dropped for one cycle would otherwise complete 1011 two bits later.
    seq("en_drop", "10_11011", "00000001", "44401234", "");

    // Mid-stream reset while the next bit would complete 1011.
    seq("pre_rst", "101", "000", "444", "");
    en = 1'b1;
    din_valid = 1'b1;
    din = 1'b1;
    rst = 1'b1;
    #1;
    check("rst_mid.match", int'(match), 0);
    check("rst_mid.fill", int'(fill), 0);
    check("rst_mid.cnt", int'(match_cnt), 0);
    @(posedge clk);
    #1;
    en = 1'b0;
    din_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    // Config must be back at reset values (pattern 0000, overlap on).
    seq("post_rst", "00000", "00011", "01234", "00001");

    // All-zero mask: every accepted bit in HUNT matches.
    load("ld_m0", 4'b1010, 4'b0000, 1'b1, 4);
    seq("mask0", "01010", "00011", "01234", "");

    // Counter: clear, 5 matches saturate at 3, clear beats coincident match.
    load("ld_cnt", 4'b1111, 4'b1111, 1'b1, 4);
    seq("cnt", "c11111111C10", "000011111110", "001234444444", "-00001233301");

    en = 1'b0;
    din_valid = 1'b0;
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_seq_pattern_detector
